// File: rtl/hazard_fwd_unit_pkg.sv
// hazard_fwd_unit_pkg
// Shared definitions for the hazard/forwarding controller:
//   - default parameter values for data/address/Tnew widths and channel count
//   - Tnew codes (cycles until a producer's result exists, measured on entry to E)
//   - Tuse codes (stage in which a consumer actually needs its operand)
//   - stage indices and record field widths used by the shadow pipeline
package hazard_fwd_unit_pkg;

  localparam int unsigned DW_DEF  = 32;
  localparam int unsigned AW_DEF  = 5;
  localparam int unsigned NCH_DEF = 2;
  localparam int unsigned TW_DEF  = 2;
  localparam int unsigned CW_DEF  = 32;

  // Tnew on entry to E
  localparam logic [1:0] TNEW_PC   = 2'd0;  // link value (PC+8) already known
  localparam logic [1:0] TNEW_ALU  = 2'd1;  // produced at the end of E
  localparam logic [1:0] TNEW_LOAD = 2'd2;  // produced at the end of M

  // Tuse: cycles from D until the operand is consumed
  localparam logic [1:0] TUSE_D = 2'd0;
  localparam logic [1:0] TUSE_E = 2'd1;
  localparam logic [1:0] TUSE_M = 2'd2;

  // Producer stages tracked by the shadow pipeline, nearest first
  typedef enum logic [1:0] {
    STG_E = 2'd0,
    STG_M = 2'd1,
    STG_W = 2'd2
  } stage_e;

  // Stage record {we, dst, tnew, src[NCH]} field widths
  localparam int unsigned REC_WE_W = 1;

  function automatic int unsigned rec_width(input int unsigned aw, input int unsigned tw,
                                            input int unsigned nch);
    rec_width = REC_WE_W + aw + tw + nch * aw;
  endfunction

endpackage

// File: rtl/hazard_fwd_unit_if.sv
// hazard_fwd_unit_if
// Bundles the D-stage request, the pipeline data sources and the forwarding
// results of hazard_fwd_unit.
//   master : pipeline side, drives instruction info and data, receives results
//   slave  : hazard_fwd_unit, receives instruction info and data, drives
//            stall, d/e/m_fwd_data and stall_cycles
interface hazard_fwd_unit_if
  import hazard_fwd_unit_pkg::*;
#(
  parameter int DW  = DW_DEF,
  parameter int AW  = AW_DEF,
  parameter int NCH = NCH_DEF,
  parameter int TW  = TW_DEF,
  parameter int CW  = CW_DEF
) ();

  logic              d_valid;
  logic [NCH*AW-1:0] d_src_addr;
  logic [NCH*TW-1:0] d_src_tuse;
  logic [AW-1:0]     d_dst_addr;
  logic              d_dst_we;
  logic [TW-1:0]     d_dst_tnew;
  logic [NCH*DW-1:0] d_rf_data;
  logic [NCH*DW-1:0] e_op_data;
  logic [NCH*DW-1:0] m_op_data;
  logic [DW-1:0]     e_res;
  logic [DW-1:0]     m_res;
  logic [DW-1:0]     w_res;
  logic              stall;
  logic [NCH*DW-1:0] d_fwd_data;
  logic [NCH*DW-1:0] e_fwd_data;
  logic [NCH*DW-1:0] m_fwd_data;
  logic [CW-1:0]     stall_cycles;

  modport master (
    output d_valid, d_src_addr, d_src_tuse, d_dst_addr, d_dst_we, d_dst_tnew,
    output d_rf_data, e_op_data, m_op_data, e_res, m_res, w_res,
    input  stall, d_fwd_data, e_fwd_data, m_fwd_data, stall_cycles
  );

  modport slave (
    input  d_valid, d_src_addr, d_src_tuse, d_dst_addr, d_dst_we, d_dst_tnew,
    input  d_rf_data, e_op_data, m_op_data, e_res, m_res, w_res,
    output stall, d_fwd_data, e_fwd_data, m_fwd_data, stall_cycles
  );

endinterface

// File: rtl/hazard_fwd_unit_fwd_pick.sv
// hazard_fwd_unit_fwd_pick
// Forwarding selector for one source operand over NS producer stages.
// Stage 0 is the nearest (youngest) producer and has the highest priority.
//   src      : consumer's source register
//   st_we    : per-stage write enable
//   st_dst   : per-stage destination, stage i at [i*AW +: AW]
//   st_tnew  : per-stage remaining Tnew, zero means the value is available
//   st_data  : per-stage result bus
//   fallback : value used when no stage matches (RF or latched operand)
//   data     : selected operand
module hazard_fwd_unit_fwd_pick
  import hazard_fwd_unit_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF,
  parameter int TW = TW_DEF,
  parameter int NS = 3
) (
  input  logic [AW-1:0]    src,
  input  logic [NS-1:0]    st_we,
  input  logic [NS*AW-1:0] st_dst,
  input  logic [NS*TW-1:0] st_tnew,
  input  logic [NS*DW-1:0] st_data,
  input  logic [DW-1:0]    fallback,
  output logic [DW-1:0]    data
);

  // Priority select: walk from the oldest stage to the nearest so the nearest
  // match is applied last. A matching stage that is not ready still decides
  // (yielding the fallback) so an older, stale value can never leak through.
  always_comb begin
    data = fallback;
    for (int i = NS - 1; i >= 0; i--) begin
      data = (st_we[i] && (st_dst[i*AW +: AW] == src) && (src != {AW{1'b0}}))
           ? ((st_tnew[i*TW +: TW] == {TW{1'b0}}) ? st_data[i*DW +: DW] : fallback)
           : data;
    end
  end

endmodule

// File: rtl/hazard_fwd_unit.sv
// hazard_fwd_unit
// Hazard and forwarding controller for the D/E/M/W pipeline. A shadow copy of
// each in-flight instruction's destination, write enable, Tnew and sources is
// kept for E, M and W; from it the unit raises stall (Tuse/Tnew rule) and
// selects forwarded operands for D, E and M consumers on NCH channels.
//   clk, reset : clock and synchronous active-high reset
//   bus        : hazard_fwd_unit_if slave (D request, data sources, results)
module hazard_fwd_unit
  import hazard_fwd_unit_pkg::*;
#(
  parameter int DW  = DW_DEF,
  parameter int AW  = AW_DEF,
  parameter int NCH = NCH_DEF,
  parameter int TW  = TW_DEF,
  parameter int CW  = CW_DEF
) (
  input logic               clk,
  input logic               reset,
  hazard_fwd_unit_if.slave  bus
);

  // Shadow stage records. W is always ready and never consumes an operand,
  // so it only needs we/dst.
  logic              e_we_r, m_we_r, w_we_r;
  logic [AW-1:0]     e_dst_r, m_dst_r, w_dst_r;
  logic [TW-1:0]     e_tnew_r, m_tnew_r;
  logic [NCH*AW-1:0] e_src_r, m_src_r;
  logic [CW-1:0]     stall_cycles_r;
  logic              stall_s;

  // Tnew counts down by one per stage advanced, stopping at zero
  function automatic logic [TW-1:0] tnew_age(input logic [TW-1:0] t);
    tnew_age = (t == {TW{1'b0}}) ? t : (t - TW'(1));
  endfunction

  // Stall when a matching E or M producer will not have its value by the
  // time the D instruction consumes it on any channel.
  always_comb begin
    stall_s = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      stall_s = stall_s
              | (e_we_r && (e_dst_r == bus.d_src_addr[k*AW +: AW])
                 && (bus.d_src_addr[k*AW +: AW] != {AW{1'b0}})
                 && (e_tnew_r > bus.d_src_tuse[k*TW +: TW]))
              | (m_we_r && (m_dst_r == bus.d_src_addr[k*AW +: AW])
                 && (bus.d_src_addr[k*AW +: AW] != {AW{1'b0}})
                 && (m_tnew_r > bus.d_src_tuse[k*TW +: TW]));
    end
    stall_s = stall_s & bus.d_valid & ~reset;
  end

  // Shadow pipeline advance and saturating stall counter
  always_ff @(posedge clk) begin
    if (reset) begin
      e_we_r         <= 1'b0;
      e_dst_r        <= {AW{1'b0}};
      e_tnew_r       <= {TW{1'b0}};
      e_src_r        <= {(NCH*AW){1'b0}};
      m_we_r         <= 1'b0;
      m_dst_r        <= {AW{1'b0}};
      m_tnew_r       <= {TW{1'b0}};
      m_src_r        <= {(NCH*AW){1'b0}};
      w_we_r         <= 1'b0;
      w_dst_r        <= {AW{1'b0}};
      stall_cycles_r <= {CW{1'b0}};
    end else begin
      m_we_r   <= e_we_r;
      m_dst_r  <= e_dst_r;
      m_tnew_r <= tnew_age(e_tnew_r);
      m_src_r  <= e_src_r;
      w_we_r   <= m_we_r;
      w_dst_r  <= m_dst_r;
      if (stall_s || !bus.d_valid) begin
        // bubble into E: held instruction during stall, or empty D slot
        e_we_r   <= 1'b0;
        e_dst_r  <= {AW{1'b0}};
        e_tnew_r <= {TW{1'b0}};
        e_src_r  <= {(NCH*AW){1'b0}};
      end else begin
        e_we_r   <= bus.d_dst_we;
        e_dst_r  <= bus.d_dst_addr;
        e_tnew_r <= bus.d_dst_tnew;
        e_src_r  <= bus.d_src_addr;
      end
      if (stall_s && (stall_cycles_r != {CW{1'b1}})) begin
        stall_cycles_r <= stall_cycles_r + CW'(1);
      end else begin
        stall_cycles_r <= stall_cycles_r;
      end
    end
  end

  assign bus.stall        = stall_s;
  assign bus.stall_cycles = stall_cycles_r;

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    // D consumers: producers E, M, W
    hazard_fwd_unit_fwd_pick #(.DW(DW), .AW(AW), .TW(TW), .NS(3)) u_pick_d (
      .src      (bus.d_src_addr[k*AW +: AW]),
      .st_we    ({w_we_r, m_we_r, e_we_r}),
      .st_dst   ({w_dst_r, m_dst_r, e_dst_r}),
      .st_tnew  ({{TW{1'b0}}, m_tnew_r, e_tnew_r}),
      .st_data  ({bus.w_res, bus.m_res, bus.e_res}),
      .fallback (bus.d_rf_data[k*DW +: DW]),
      .data     (bus.d_fwd_data[k*DW +: DW])
    );

    // E consumers: producers M, W
    hazard_fwd_unit_fwd_pick #(.DW(DW), .AW(AW), .TW(TW), .NS(2)) u_pick_e (
      .src      (e_src_r[k*AW +: AW]),
      .st_we    ({w_we_r, m_we_r}),
      .st_dst   ({w_dst_r, m_dst_r}),
      .st_tnew  ({{TW{1'b0}}, m_tnew_r}),
      .st_data  ({bus.w_res, bus.m_res}),
      .fallback (bus.e_op_data[k*DW +: DW]),
      .data     (bus.e_fwd_data[k*DW +: DW])
    );

    // M consumers: producer W only
    hazard_fwd_unit_fwd_pick #(.DW(DW), .AW(AW), .TW(TW), .NS(1)) u_pick_m (
      .src      (m_src_r[k*AW +: AW]),
      .st_we    (w_we_r),
      .st_dst   (w_dst_r),
      .st_tnew  ({TW{1'b0}}),
      .st_data  (bus.w_res),
      .fallback (bus.m_op_data[k*DW +: DW]),
      .data     (bus.m_fwd_data[k*DW +: DW])
    );
  end

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// tb_hazard_fwd_unit
// Scoreboard bench: a driver applies one D-stage request per cycle, computes
// the expected outputs from an instruction-level pipeline model and queues
// them; a monitor on the falling edge pops and compares against the DUT.
module tb_hazard_fwd_unit;
  import hazard_fwd_unit_pkg::*;

  localparam int DW = 32, AW = 5, NCH = 2, TW = 2, CW = 32;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  hazard_fwd_unit_if #(.DW(DW), .AW(AW), .NCH(NCH), .TW(TW), .CW(CW)) bus ();

  hazard_fwd_unit #(.DW(DW), .AW(AW), .NCH(NCH), .TW(TW), .CW(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // One instruction as issued: Tnew is the value it had when entering E
  typedef struct packed {
    logic       we;
    logic [4:0] dst;
    logic [1:0] tnew;
    logic [4:0] src0;
    logic [4:0] src1;
  } instr_t;

  typedef struct packed {
    logic        stall;
    logic [31:0] sc;
    logic [63:0] d, e, m;
    logic [1:0]  dc, ec, mc;
    logic        pin_stall_en, pin_stall;
    logic        pin_d0_en;
    logic [31:0] pin_d0;
    logic        pin_e0_en;
    logic [31:0] pin_e0;
    logic        pin_sc_en;
    logic [31:0] pin_sc;
  } exp_t;

  instr_t      pipe [3];  // 0 = E, 1 = M, 2 = W
  logic [31:0] sc_model;
  exp_t        sb [$];
  int          checks = 0;
  int          failures = 0;

  logic [31:0] rf [2];
  logic [31:0] eop [2];
  logic [31:0] mop [2];
  logic [31:0] eres, mres, wres;
  logic        pin_stall_en = 1'b0, pin_stall = 1'b0;
  logic        pin_d0_en = 1'b0, pin_e0_en = 1'b0, pin_sc_en = 1'b0;
  logic [31:0] pin_d0 = 32'd0, pin_e0 = 32'd0, pin_sc = 32'd0;

  // Cycles still needed before the instruction at depth d has its result
  function automatic int remaining(input int d);
    int t;
    t = int'(pipe[d].tnew) - d;
    if (d == 2 || t < 0) return 0;
    return t;
  endfunction

  function automatic bit hit(input int d, input logic [4:0] s);
    return (s != 5'd0) && pipe[d].we && (pipe[d].dst == s);
  endfunction

  function automatic logic [4:0] srcof(input instr_t r, input int k);
    return (k == 0) ? r.src0 : r.src1;
  endfunction

  function automatic logic [31:0] res_of(input int d);
    if (d == 0) return eres;
    if (d == 1) return mres;
    return wres;
  endfunction

  task automatic chk(input string nm, input int ch, input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s ch%0d got=%h expected=%h", nm, ch, got, want);
    end
  endtask

  // Apply one cycle of D-stage stimulus, queue the expectation, advance model
  task automatic cyc(input logic rst, input logic v, input logic [4:0] s0, input logic [4:0] s1,
                     input logic [1:0] u0, input logic [1:0] u1, input logic [4:0] dst,
                     input logic we, input logic [1:0] tn);
    exp_t       x;
    instr_t     nw;
    bit         stl, found;
    logic [4:0] s [2];
    logic [1:0] u [2];
    logic [4:0] es;
    @(posedge clk);
    #1;
    reset          = rst;
    bus.d_valid    = v;
    bus.d_src_addr = {s1, s0};
    bus.d_src_tuse = {u1, u0};
    bus.d_dst_addr = dst;
    bus.d_dst_we   = we;
    bus.d_dst_tnew = tn;
    bus.d_rf_data  = {rf[1], rf[0]};
    bus.e_op_data  = {eop[1], eop[0]};
    bus.m_op_data  = {mop[1], mop[0]};
    bus.e_res      = eres;
    bus.m_res      = mres;
    bus.w_res      = wres;
    s[0] = s0; s[1] = s1; u[0] = u0; u[1] = u1;
    x = '0;

    stl = 1'b0;
    for (int k = 0; k < 2; k++)
      for (int d = 0; d < 2; d++)
        if (hit(d, s[k]) && remaining(d) > int'(u[k])) stl = 1'b1;
    if (rst || !v) stl = 1'b0;
    x.stall = stl;
    x.sc    = sc_model;

    for (int k = 0; k < 2; k++) begin
      // D consumer: nearest of E, M, W
      x.d[k*32 +: 32] = rf[k]; x.dc[k] = 1'b1; found = 1'b0;
      for (int d = 0; d < 3; d++)
        if (!found && hit(d, s[k])) begin
          found = 1'b1;
          if (remaining(d) == 0) x.d[k*32 +: 32] = res_of(d);
          else x.dc[k] = 1'b0;
        end
      // E consumer: nearest of M, W
      es = srcof(pipe[0], k);
      x.e[k*32 +: 32] = eop[k]; x.ec[k] = 1'b1; found = 1'b0;
      for (int d = 1; d < 3; d++)
        if (!found && hit(d, es)) begin
          found = 1'b1;
          if (remaining(d) == 0) x.e[k*32 +: 32] = res_of(d);
          else x.ec[k] = 1'b0;
        end
      // M consumer: W only
      x.m[k*32 +: 32] = hit(2, srcof(pipe[1], k)) ? wres : mop[k];
      x.mc[k] = 1'b1;
    end

    x.pin_stall_en = pin_stall_en; x.pin_stall = pin_stall;
    x.pin_d0_en = pin_d0_en; x.pin_d0 = pin_d0;
    x.pin_e0_en = pin_e0_en; x.pin_e0 = pin_e0;
    x.pin_sc_en = pin_sc_en; x.pin_sc = pin_sc;
    pin_stall_en = 1'b0; pin_d0_en = 1'b0; pin_e0_en = 1'b0; pin_sc_en = 1'b0;
    sb.push_back(x);

    if (rst) begin
      for (int d = 0; d < 3; d++) pipe[d] = '0;
      sc_model = 32'd0;
    end else begin
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      nw.we = we; nw.dst = dst; nw.tnew = tn; nw.src0 = s0; nw.src1 = s1;
      pipe[0] = (stl || !v) ? instr_t'(0) : nw;
      if (stl && sc_model != 32'hFFFF_FFFF) sc_model = sc_model + 32'd1;
    end
  endtask

  // Monitor: compare the DUT outputs of this cycle with the queued expectation
  always @(negedge clk) begin
    exp_t x;
    if (sb.size() > 0) begin
      x = sb.pop_front();
      chk("stall", 0, {31'd0, bus.stall}, {31'd0, x.stall});
      chk("stall_cycles", 0, bus.stall_cycles, x.sc);
      for (int k = 0; k < 2; k++) begin
        if (x.dc[k]) chk("d_fwd", k, bus.d_fwd_data[k*32 +: 32], x.d[k*32 +: 32]);
        if (x.ec[k]) chk("e_fwd", k, bus.e_fwd_data[k*32 +: 32], x.e[k*32 +: 32]);
        if (x.mc[k]) chk("m_fwd", k, bus.m_fwd_data[k*32 +: 32], x.m[k*32 +: 32]);
      end
      if (x.pin_stall_en) chk("dir_stall", 0, {31'd0, bus.stall}, {31'd0, x.pin_stall});
      if (x.pin_d0_en) chk("dir_d_fwd", 0, bus.d_fwd_data[31:0], x.pin_d0);
      if (x.pin_e0_en) chk("dir_e_fwd", 0, bus.e_fwd_data[31:0], x.pin_e0);
      if (x.pin_sc_en) chk("dir_stall_cycles", 0, bus.stall_cycles, x.pin_sc);
    end
  end

  initial begin
    for (int d = 0; d < 3; d++) pipe[d] = '0;
    sc_model = 32'd0;
    rf[0] = 32'h0AAA_0000; rf[1] = 32'h0BBB_0000;
    eop[0] = 32'h0E00_0000; eop[1] = 32'h0E11_0000;
    mop[0] = 32'h0D00_0000; mop[1] = 32'h0D11_0000;
    eres = 32'h0000_0E5E; mres = 32'h0000_0A5A; wres = 32'h0000_0B5B;
    bus.d_valid = 1'b0; bus.d_src_addr = '0; bus.d_src_tuse = '0;
    bus.d_dst_addr = '0; bus.d_dst_we = 1'b0; bus.d_dst_tnew = '0;
    bus.d_rf_data = '0; bus.e_op_data = '0; bus.m_op_data = '0;
    bus.e_res = '0; bus.m_res = '0; bus.w_res = '0;
    reset = 1'b1;
    repeat (2) @(posedge clk);

    // Reset state
    pin_stall_en = 1'b1; pin_stall = 1'b0;
    cyc(1'b1, 1'b0, 5'd0, 5'd0, TUSE_M, TUSE_M, 5'd0, 1'b0, TNEW_PC);

    // add $3 then beq $3: one stall, then forwarded from M
    cyc(1'b0, 1'b1, 5'd0, 5'd0, TUSE_M, TUSE_M, 5'd3, 1'b1, TNEW_ALU);
    pin_stall_en = 1'b1; pin_stall = 1'b1;
    cyc(1'b0, 1'b1, 5'd3, 5'd0, TUSE_D, TUSE_D, 5'd0, 1'b0, TNEW_PC);
    mres = 32'h0000_1234;
    pin_stall_en = 1'b1; pin_stall = 1'b0;
    pin_d0_en = 1'b1; pin_d0 = 32'h0000_1234;
    pin_sc_en = 1'b1; pin_sc = 32'd1;
    cyc(1'b0, 1'b1, 5'd3, 5'd0, TUSE_D, TUSE_D, 5'd0, 1'b0, TNEW_PC);

    // lw $4 then add using $4 in E: one stall, then W forwards into E
    cyc(1'b0, 1'b1, 5'd0, 5'd0, TUSE_M, TUSE_M, 5'd4, 1'b1, TNEW_LOAD);
    pin_stall_en = 1'b1; pin_stall = 1'b1;
    cyc(1'b0, 1'b1, 5'd4, 5'd0, TUSE_E, TUSE_E, 5'd6, 1'b1, TNEW_ALU);
    pin_stall_en = 1'b1; pin_stall = 1'b0;
    cyc(1'b0, 1'b1, 5'd4, 5'd0, TUSE_E, TUSE_E, 5'd6, 1'b1, TNEW_ALU);
    wres = 32'hDEAD_BEEF;
    pin_e0_en = 1'b1; pin_e0 = 32'hDEAD_BEEF;
    pin_sc_en = 1'b1; pin_sc = 32'd2;
    cyc(1'b0, 1'b0, 5'd0, 5'd0, TUSE_M, TUSE_M, 5'd0, 1'b0, TNEW_PC);

    // jal then jr $31: no stall, link value from E
    cyc(1'b0, 1'b1, 5'd0, 5'd0, TUSE_M, TUSE_M, 5'd31, 1'b1, TNEW_PC);
    eres = 32'h0000_3008;
    pin_stall_en = 1'b1; pin_stall = 1'b0;
    pin_d0_en = 1'b1; pin_d0 = 32'h0000_3008;
    cyc(1'b0, 1'b1, 5'd31, 5'd0, TUSE_D, TUSE_D, 5'd0, 1'b0, TNEW_PC);

    // lw $0 then reader of $0: never a hazard
    cyc(1'b0, 1'b1, 5'd0, 5'd0, TUSE_M, TUSE_M, 5'd0, 1'b1, TNEW_LOAD);
    rf[0] = 32'd0;
    pin_stall_en = 1'b1; pin_stall = 1'b0;
    pin_d0_en = 1'b1; pin_d0 = 32'd0;
    cyc(1'b0, 1'b1, 5'd0, 5'd0, TUSE_D, TUSE_D, 5'd0, 1'b0, TNEW_PC);

    // M and W both write $5: nearest (M) wins
    cyc(1'b0, 1'b1, 5'd0, 5'd0, TUSE_M, TUSE_M, 5'd5, 1'b1, TNEW_ALU);
    cyc(1'b0, 1'b1, 5'd0, 5'd0, TUSE_M, TUSE_M, 5'd5, 1'b1, TNEW_ALU);
    cyc(1'b0, 1'b0, 5'd0, 5'd0, TUSE_M, TUSE_M, 5'd0, 1'b0, TNEW_PC);
    mres = 32'h0000_0011; wres = 32'h0000_0022;
    pin_stall_en = 1'b1; pin_stall = 1'b0;
    pin_d0_en = 1'b1; pin_d0 = 32'h0000_0011;
    cyc(1'b0, 1'b1, 5'd5, 5'd0, TUSE_D, TUSE_D, 5'd0, 1'b0, TNEW_PC);

    // load-use stall interrupted by reset
    cyc(1'b0, 1'b1, 5'd0, 5'd0, TUSE_M, TUSE_M, 5'd7, 1'b1, TNEW_LOAD);
    pin_stall_en = 1'b1; pin_stall = 1'b1;
    cyc(1'b0, 1'b1, 5'd7, 5'd0, TUSE_D, TUSE_D, 5'd0, 1'b0, TNEW_PC);
    pin_stall_en = 1'b1; pin_stall = 1'b0;
    cyc(1'b1, 1'b1, 5'd7, 5'd0, TUSE_D, TUSE_D, 5'd0, 1'b0, TNEW_PC);
    rf[0] = 32'hCAFE_0000;
    pin_stall_en = 1'b1; pin_stall = 1'b0;
    pin_sc_en = 1'b1; pin_sc = 32'd0;
    pin_d0_en = 1'b1; pin_d0 = 32'hCAFE_0000;
    cyc(1'b0, 1'b1, 5'd7, 5'd0, TUSE_D, TUSE_D, 5'd0, 1'b0, TNEW_PC);

    // Randomized traffic over a small register set to provoke hazards
    for (int n = 0; n < 1500; n++) begin
      for (int k = 0; k < 2; k++) begin
        rf[k] = $urandom; eop[k] = $urandom; mop[k] = $urandom;
      end
      eres = $urandom; mres = $urandom; wres = $urandom;
      cyc(($urandom_range(0, 49) == 0) ? 1'b1 : 1'b0,
          ($urandom_range(0, 4) != 0) ? 1'b1 : 1'b0,
          5'($urandom_range(0, 4)), 5'($urandom_range(0, 4)),
          2'($urandom_range(0, 2)), 2'($urandom_range(0, 2)),
          5'($urandom_range(0, 4)), 1'($urandom_range(0, 1)),
          2'($urandom_range(0, 2)));
    end

    // Drain the scoreboard within a bounded number of cycles
    for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge clk);
    #1;
    checks++;
    if (sb.size() > 0) begin
      failures++;
      $display("FAIL drain pending=%0d expected=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
